// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//
// Shared definitions for the 16-bit CPU instruction bus. The fetch unit that
// produces instructions and the decoder that consumes them both import this
// package, so they agree on widths, field positions and the HALT encoding.
//
// Contents:
//   ADDR_W / INSTR_W   program-counter and instruction widths
//   *_MSB / *_LSB      instruction field positions
//   HALT_OPCODE        opcode that stops instruction fetch
//   fetch_state_e      fetch-unit state encoding
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 16;

    // Instruction layout: [15:12] opcode, [11:10] reg1, [9:8] reg2, [7:0] adr
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned REG1_MSB = 11;
    localparam int unsigned REG1_LSB = 10;
    localparam int unsigned REG2_MSB = 9;
    localparam int unsigned REG2_LSB = 8;
    localparam int unsigned ADR_MSB  = 7;
    localparam int unsigned ADR_LSB  = 0;

    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_FETCH,
        FS_WAIT,
        FS_ISSUE,
        FS_HALT
    } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Sequential instruction fetch: holds the PC, reads one word at a time from
// program memory over a request/valid port and offers it to the decoder with
// a valid/ready handshake. The decoder's pc_jump selects the next PC; a HALT
// opcode stops fetching until reset.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   run           level-sensitive fetch enable
//   imem_req      one-cycle read strobe to program memory
//   imem_addr     read address (PC while imem_req, else 0)
//   imem_rdata    read data, qualified by imem_valid
//   imem_valid    read data valid
//   instr         registered instruction to decoder
//   instr_valid   instr is valid
//   instr_ready   decoder accepts instr
//   pc_jump       decoder jump decision, sampled on the handshake only
//   pc            address of the next or current fetch
//   halted        HALT retired; sticky until rst
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned                  ADDR_W      = cpu_pkg::ADDR_W,
    parameter int unsigned                  INSTR_W     = cpu_pkg::INSTR_W,
    parameter logic [OPC_MSB-OPC_LSB:0]     HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pc_jump,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    localparam int unsigned ADR_W = ADR_MSB - ADR_LSB + 1;

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q,    pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    logic handshake;
    logic is_halt;

    // Next-PC mux: jump target is zero-extended or truncated to the PC width;
    // the sequential increment wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] next_pc(
        input logic [ADDR_W-1:0] cur_pc,
        input logic [ADR_W-1:0]  target,
        input logic              jump
    );
        if (jump) begin
            return ADDR_W'(target);
        end
        return cur_pc + ADDR_W'(1);
    endfunction

    assign handshake = (state_q == FS_ISSUE) && instr_ready;
    assign is_halt   = (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;

        case (state_q)
            FS_IDLE: begin
                if (run) begin
                    state_d = FS_FETCH;
                end
            end
            FS_FETCH: begin
                state_d = FS_WAIT;
            end
            FS_WAIT: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = FS_ISSUE;
                end
            end
            FS_ISSUE: begin
                if (handshake) begin
                    if (is_halt) begin
                        // HALT wins over any jump decision; PC stays put.
                        state_d = FS_HALT;
                    end else begin
                        pc_d    = next_pc(pc_q, instr_q[ADR_MSB:ADR_LSB], pc_jump);
                        state_d = run ? FS_FETCH : FS_IDLE;
                    end
                end
            end
            FS_HALT: begin
                state_d = FS_HALT;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of process ordering.
        if (rst) begin
            state_q <= FS_IDLE;
            pc_q    <= '0;
            // NOTE: the instruction register is reset too, so the decoder bus
            // shows a known word after reset rather than stale data.
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode directly from the registered state, so they are glitch
    // free relative to the clock and quiet in IDLE.
    assign imem_req    = (state_q == FS_FETCH);
    assign imem_addr   = imem_req ? pc_q : '0;
    assign instr       = instr_q;
    assign instr_valid = (state_q == FS_ISSUE);
    assign pc          = pc_q;
    assign halted      = (state_q == FS_HALT);

endmodule : instr_fetch_unit

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit: a behavioural program memory with a
// configurable number of wait cycles, a request logger, and hand-computed
// expectations for sequential fetch, jump, PC wrap, back-pressure, HALT and
// reset during an outstanding read.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_jump;
    logic [7:0]  pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 0;

    logic [15:0] mem [256];
    logic [7:0]  req_addr[$];
    int          req_cyc[$];

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_jump     (pc_jump),
        .pc          (pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every read strobe with its address and cycle.
    always @(negedge clk) begin
        if (imem_req) begin
            req_addr.push_back(imem_addr);
            req_cyc.push_back(cyc);
        end
    end

    // Program memory: answers each strobe mem_lat+1 cycles later for one cycle.
    initial begin
        logic [7:0] a;
        imem_valid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (imem_req) begin
                a = imem_addr;
                repeat (mem_lat) @(posedge clk);
                @(posedge clk);
                #1;
                imem_valid = 1'b1;
                imem_rdata = mem[a];
                @(posedge clk);
                #1;
                imem_valid = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for an issued word, check it, and drive the decoder's
    // jump decision and the run level for its handshake cycle.
    task automatic retire(input string tag, input logic [15:0] exp,
                          input logic jmp, input logic run_nxt);
        int n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_instr"}, 32'(instr), 32'(exp));
        pc_jump = jmp;
        run     = run_nxt;
        @(posedge clk);
        #1;
        pc_jump = 1'b0;
    endtask

    initial begin
        int          run_cyc;
        int          n;
        logic [15:0] held;
        logic [7:0]  exp_addr [7];

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h1100;
        mem[8'h01] = 16'h2201;
        mem[8'h02] = 16'h4D40;
        mem[8'h03] = 16'h3303;
        mem[8'h40] = 16'h50FF;
        mem[8'hFF] = 16'h6000;

        rst         = 1'b1;
        run         = 1'b0;
        instr_ready = 1'b1;
        pc_jump     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req",    32'(imem_req),    32'd0);
        check("rst_addr",   32'(imem_addr),   32'd0);
        check("rst_instr",  32'(instr),       32'd0);
        check("rst_ivalid", 32'(instr_valid), 32'd0);
        check("rst_pc",     32'(pc),          32'd0);
        check("rst_halted", 32'(halted),      32'd0);

        // Sequential fetch of 0..3, then drop run on the last issue
        @(posedge clk);
        #1;
        run     = 1'b1;
        run_cyc = cyc;
        retire("seq0", 16'h1100, 1'b0, 1'b1);
        retire("seq1", 16'h2201, 1'b0, 1'b1);
        retire("seq2", 16'h4D40, 1'b0, 1'b1);
        retire("seq3", 16'h3303, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        check("seq_nreq", 32'(req_addr.size()), 32'd4);
        if (req_addr.size() == 4) begin
            check("seq_first_req_cyc", 32'(req_cyc[0]), 32'(run_cyc + 1));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("seq_addr%0d", i), 32'(req_addr[i]), 32'(i));
            end
            for (int i = 0; i < 3; i++) begin
                check($sformatf("seq_gap%0d", i), 32'(req_cyc[i + 1] - req_cyc[i]), 32'd3);
            end
        end
        check("park_pc",     32'(pc),          32'd4);
        check("park_ivalid", 32'(instr_valid), 32'd0);
        check("park_req",    32'(imem_req),    32'd0);

        // Jump at 2 to 0x40, jump to 0xFF, then wrap to 0x00
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_addr.delete();
        req_cyc.delete();
        run = 1'b1;
        retire("j0",  16'h1100, 1'b0, 1'b1);
        retire("j1",  16'h2201, 1'b0, 1'b1);
        retire("j2",  16'h4D40, 1'b1, 1'b1);
        retire("j40", 16'h50FF, 1'b1, 1'b1);
        retire("jff", 16'h6000, 1'b0, 1'b1);

        // Back-pressure on the word refetched from 0x00
        instr_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!instr_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("bp_valid_seen", 32'(instr_valid), 32'd1);
        held = instr;
        check("bp_word", 32'(held), 32'h1100);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_instr%0d", k),  32'(instr),       32'(held));
            check($sformatf("bp_ivalid%0d", k), 32'(instr_valid), 32'd1);
            check($sformatf("bp_req%0d", k),    32'(imem_req),    32'd0);
            @(negedge clk);
        end
        mem[8'h01]  = 16'hF000;
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_retired_ivalid", 32'(instr_valid), 32'd0);
        check("bp_next_req",       32'(imem_req),    32'd1);
        check("bp_next_addr",      32'(imem_addr),   32'h01);

        // HALT at address 1, with pc_jump asserted to show HALT wins
        retire("halt", 16'hF000, 1'b1, 1'b1);
        @(negedge clk);
        check("halt_halted", 32'(halted),      32'd1);
        check("halt_pc",     32'(pc),          32'h01);
        check("halt_ivalid", 32'(instr_valid), 32'd0);
        repeat (10) @(negedge clk);
        check("halt_sticky", 32'(halted),   32'd1);
        check("halt_noreq",  32'(imem_req), 32'd0);
        exp_addr = '{8'h00, 8'h01, 8'h02, 8'h40, 8'hFF, 8'h00, 8'h01};
        check("jmp_nreq", 32'(req_addr.size()), 32'd7);
        if (req_addr.size() == 7) begin
            for (int i = 0; i < 7; i++) begin
                check($sformatf("jmp_addr%0d", i), 32'(req_addr[i]), 32'(exp_addr[i]));
            end
        end

        // Reset while a read is outstanding; data arrives after reset
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        mem[8'h01] = 16'h2201;
        mem_lat    = 1;
        @(negedge clk);
        check("unhalt", 32'(halted), 32'd0);
        @(posedge clk);
        #1;
        run = 1'b1;
        retire("r0", 16'h1100, 1'b0, 1'b1);
        @(negedge clk);
        check("mr_fetch_req",  32'(imem_req),  32'd1);
        check("mr_fetch_addr", 32'(imem_addr), 32'h01);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_req",    32'(imem_req),    32'd0);
        check("mr_addr",   32'(imem_addr),   32'd0);
        check("mr_instr",  32'(instr),       32'd0);
        check("mr_ivalid", 32'(instr_valid), 32'd0);
        check("mr_pc",     32'(pc),          32'd0);
        check("mr_halted", 32'(halted),      32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mr_late_ivalid%0d", k), 32'(instr_valid), 32'd0);
            check($sformatf("mr_late_instr%0d", k),  32'(instr),       32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_instr_fetch_unit
